// File: rtl/spi_burst_ctrl_if.sv
// rtl/spi_burst_ctrl_if.sv - host/SPI-master signal bundle for spi_burst_ctrl; `SPI_BURST_ABORT_EN adds abort/aborted
// slave = the controller, master = the host plus byte-level SPI master around it.
interface spi_burst_ctrl_if #(
    parameter int LEN_W = 4
);
    logic             start;
    logic             rw;
    logic [6:0]       addr;
    logic [LEN_W-1:0] len;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             busy;
    logic             done;
    logic             cs_n;
    logic             spi_start;
    logic [7:0]       spi_tx;
    logic             spi_busy;
    logic             spi_new_data;
    logic [7:0]       spi_rx;
`ifdef SPI_BURST_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    modport slave (
        input  start, rw, addr, len, wr_data, wr_valid, spi_busy, spi_new_data, spi_rx,
`ifdef SPI_BURST_ABORT_EN
        input  abort,
        output aborted,
`endif
        output wr_ready, rd_data, rd_valid, busy, done, cs_n, spi_start, spi_tx
    );

    modport master (
        output start, rw, addr, len, wr_data, wr_valid, spi_busy, spi_new_data, spi_rx,
`ifdef SPI_BURST_ABORT_EN
        output abort,
        input  aborted,
`endif
        input  wr_ready, rd_data, rd_valid, busy, done, cs_n, spi_start, spi_tx
    );
endinterface

// File: rtl/spi_burst_ctrl.sv
// rtl/spi_burst_ctrl.sv - SPI burst sequencer: one {rw,addr} byte then len data bytes under one cs_n window
// Optional early termination is compiled in with `SPI_BURST_ABORT_EN.
module spi_burst_ctrl #(
    parameter int         LEN_W  = 4,
    parameter int         CS_DLY = 2,
    parameter logic [7:0] DUMMY  = 8'h00
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_burst_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, ADDR, WAIT_A, FETCH, XFER, WAIT_D, HOLD} state_e;

    localparam logic [7:0]       DLY_LAST = 8'(CS_DLY - 1);
    localparam logic [LEN_W-1:0] REM_ONE  = LEN_W'(1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             rw_q, rw_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             done_q, done_d;
    logic             ab_q, ab_d;
    logic             spi_start;
    logic             wr_ready;
    logic             abort_req;

`ifdef SPI_BURST_ABORT_EN
    logic aborted_q;
    assign abort_req = bus.abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) aborted_q <= 1'b0;
        else        aborted_q <= done_d & ab_q;
    end
    assign bus.aborted = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            rw_q       <= 1'b0;
            tx_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            ab_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            rw_q       <= rw_d;
            tx_q       <= tx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            ab_q       <= ab_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        rw_d       = rw_q;
        tx_d       = tx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        ab_d       = ab_q;
        spi_start  = 1'b0;
        wr_ready   = 1'b0;
        case (state_q)
            // done_q marks the first IDLE cycle; a start there is dropped so a gap always exists
            IDLE: if (bus.start && !done_q) begin
                rw_d    = bus.rw;
                rem_d   = bus.len;
                tx_d    = {bus.rw, bus.addr};
                cnt_d   = '0;
                ab_d    = 1'b0;
                state_d = SETUP;
            end
            SETUP: begin
                if (abort_req) begin
                    ab_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else if (cnt_q == DLY_LAST) begin
                    cnt_d   = '0;
                    state_d = ADDR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ADDR: if (!bus.spi_busy) begin
                spi_start = 1'b1;
                state_d   = WAIT_A;
            end
            WAIT_A: begin
                if (abort_req) ab_d = 1'b1;
                if (bus.spi_new_data) begin
                    if (rem_q == '0 || ab_d) begin
                        state_d = HOLD;
                    end else if (rw_q) begin
                        tx_d    = DUMMY;
                        state_d = XFER;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                wr_ready = !abort_req;
                if (abort_req) begin
                    ab_d    = 1'b1;
                    state_d = HOLD;
                end else if (bus.wr_valid) begin
                    tx_d    = bus.wr_data;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (abort_req) begin
                    ab_d    = 1'b1;
                    state_d = HOLD;
                end else if (!bus.spi_busy) begin
                    spi_start = 1'b1;
                    state_d   = WAIT_D;
                end
            end
            WAIT_D: begin
                if (abort_req) ab_d = 1'b1;
                if (bus.spi_new_data) begin
                    if (rem_q != '0) rem_d = rem_q - REM_ONE;
                    if (rw_q) begin
                        rd_data_d  = bus.spi_rx;
                        rd_valid_d = 1'b1;
                    end
                    if (rem_q <= REM_ONE || ab_d) state_d = HOLD;
                    else if (rw_q)               state_d = XFER;
                    else                         state_d = FETCH;
                end
            end
            HOLD: begin
                if (cnt_q == DLY_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cs_n      = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.spi_start = spi_start;
    assign bus.spi_tx    = tx_q;
    assign bus.wr_ready  = wr_ready;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb/tb_spi_burst_ctrl.sv - randomized self-checking bench for spi_burst_ctrl (`SPI_BURST_ABORT_EN adds the abort case)
`timescale 1ns/1ps
module tb_spi_burst_ctrl;
    localparam int         LEN_W  = 4;
    localparam int         CS_DLY = 3;
    localparam logic [7:0] DUMMY  = 8'h00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_burst_ctrl_if #(.LEN_W(LEN_W)) bif();

    spi_burst_ctrl #(.LEN_W(LEN_W), .CS_DLY(CS_DLY), .DUMMY(DUMMY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] tx_log[$];
    int         start_cyc_log[$];
    logic [7:0] rx_log[$];
    logic [7:0] rx_preset[$];
    logic [7:0] rd_log[$];
    logic [7:0] wexp[$];
    logic [7:0] wq[$];
    int done_cnt, done_cyc, cs_low_cnt, cs_fall_cyc, last_nd_cyc, wr_ready_cnt;
    int spi_viol, tx_hold_err, aborted_cnt;
    logic done_cs, done_busy;
    int lat_max = 3;
    bit stall_en = 0;
    int hold_cycles = 0, hold_rdy = 0, rel_cyc = 0, starts_at_rel = 0;

    task automatic clear_logs();
        tx_log.delete(); start_cyc_log.delete(); rx_log.delete(); rd_log.delete();
        done_cnt = 0; done_cyc = 0; cs_low_cnt = 0; cs_fall_cyc = -1; last_nd_cyc = 0;
        wr_ready_cnt = 0; spi_viol = 0; tx_hold_err = 0; aborted_cnt = 0;
        done_cs = 1'b0; done_busy = 1'b1;
    endtask

    // Byte-level SPI master: takes a start, goes busy for a random latency, returns a byte
    initial begin : spi_model
        int phase;
        int lat;
        logic [7:0] cur;
        phase = 0; lat = 0; cur = '0;
        bif.spi_busy = 1'b0; bif.spi_new_data = 1'b0; bif.spi_rx = '0;
        forever begin
            @(negedge clk);
            bif.spi_new_data = 1'b0;
            if (!rst_n) begin
                phase = 0;
                bif.spi_busy = 1'b0;
            end else if (phase == 0) begin
                if (bif.spi_start) begin
                    tx_log.push_back(bif.spi_tx);
                    start_cyc_log.push_back(cyc);
                    cur = bif.spi_tx;
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (bif.spi_start) spi_viol++;
                bif.spi_busy = 1'b1;
                lat = $urandom_range(1, lat_max);
                phase = 2;
            end else begin
                if (bif.spi_start) spi_viol++;
                lat--;
                if (lat == 0) begin
                    if (bif.spi_tx !== cur) tx_hold_err++;
                    bif.spi_busy = 1'b0;
                    bif.spi_new_data = 1'b1;
                    bif.spi_rx = (rx_preset.size() > 0) ? rx_preset.pop_front() : 8'($urandom);
                    rx_log.push_back(bif.spi_rx);
                    last_nd_cyc = cyc;
                    phase = 0;
                end
            end
        end
    end

    // Write-stream source: offers queued bytes even outside FETCH; only wr_ready consumes them
    initial begin : wr_feeder
        bit hs, hold_act, rel_pend;
        hs = 0; hold_act = 0; rel_pend = 0;
        bif.wr_valid = 1'b0; bif.wr_data = '0;
        forever begin
            @(negedge clk);
            if (hs && wq.size() > 0) void'(wq.pop_front());
            if (!rst_n) begin
                bif.wr_valid = 1'b0;
            end else if (hold_cycles > 0 && (hold_act || bif.wr_ready)) begin
                hold_act = 1;
                bif.wr_valid = 1'b0;
                if (bif.wr_ready) hold_rdy++;
                hold_cycles--;
                if (hold_cycles == 0) begin
                    hold_act = 0;
                    rel_pend = 1;
                    starts_at_rel = tx_log.size();
                end
            end else begin
                if (rel_pend) begin
                    rel_cyc = cyc;
                    rel_pend = 0;
                end
                if (wq.size() > 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
                    bif.wr_valid = 1'b1;
                    bif.wr_data = wq[0];
                end else begin
                    bif.wr_valid = 1'b0;
                    bif.wr_data = 8'($urandom);
                end
            end
            hs = bif.wr_valid && bif.wr_ready;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bif.rd_valid) rd_log.push_back(bif.rd_data);
            if (bif.done) begin
                done_cnt++;
                done_cyc = cyc;
                done_cs = bif.cs_n;
                done_busy = bif.busy;
`ifdef SPI_BURST_ABORT_EN
                if (bif.aborted) aborted_cnt++;
`endif
            end
            if (!bif.cs_n) begin
                cs_low_cnt++;
                if (cs_fall_cyc < 0) cs_fall_cyc = cyc;
            end
            if (bif.wr_ready) wr_ready_cnt++;
        end
    end

    task automatic wait_done();
        int t;
        t = 0;
        while (bif.done !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_seen", 32'(t < 3000), 1);
    endtask

    task automatic wait_bytes(input int n);
        int t;
        t = 0;
        while (tx_log.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("reach_byte", 32'(t < 500), 1);
    endtask

    // Reference: byte list {rw,addr} then write data or DUMMY; read data = rx of bytes 1..len
    task automatic check_txn(input logic r, input logic [6:0] a, input int n, input int s_cyc);
        logic [7:0] e;
        check_eq("n_bytes", tx_log.size(), n + 1);
        for (int i = 0; i < tx_log.size() && i <= n; i++) begin
            if (i == 0)  e = {r, a};
            else if (r)  e = DUMMY;
            else         e = wexp[i-1];
            check_eq("tx_byte", tx_log[i], e);
        end
        check_eq("n_rd", rd_log.size(), r ? n : 0);
        for (int i = 0; i < rd_log.size() && i < n && i + 1 < rx_log.size(); i++)
            check_eq("rd_byte", rd_log[i], rx_log[i+1]);
        check_eq("done_cnt", done_cnt, 1);
        check_eq("done_cs_n", done_cs, 1);
        check_eq("done_busy", done_busy, 0);
        check_eq("cs_setup", cs_fall_cyc - s_cyc, 1);
        check_eq("addr_after_setup", start_cyc_log.size() > 0 ? start_cyc_log[0] - cs_fall_cyc : -1, CS_DLY);
        check_eq("cs_hold", done_cyc - last_nd_cyc, CS_DLY + 1);
        check_eq("cs_low_span", cs_low_cnt, done_cyc - cs_fall_cyc);
        check_eq("spi_protocol", spi_viol, 0);
        check_eq("tx_stable", tx_hold_err, 0);
        if (r || n == 0) check_eq("no_wr_ready", wr_ready_cnt, 0);
        else             check_eq("wr_consumed", wq.size(), 0);
`ifdef SPI_BURST_ABORT_EN
        check_eq("not_aborted", aborted_cnt, 0);
`endif
    endtask

    task automatic run_txn(input logic r, input logic [6:0] a, input int n, input bit sod);
        int s_cyc;
        clear_logs();
        if (!r && wexp.size() == 0)
            for (int i = 0; i < n; i++) wexp.push_back(8'($urandom));
        wq = wexp;
        @(negedge clk);
        bif.start = 1'b1; bif.rw = r; bif.addr = a; bif.len = LEN_W'(n);
        s_cyc = cyc;
        @(negedge clk);
        bif.start = 1'b0; bif.rw = ~r; bif.addr = ~a; bif.len = ~LEN_W'(n);
        repeat (3) @(negedge clk);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        wait_done();
        if (sod) begin
            bif.start = 1'b1;
            @(negedge clk);
            bif.start = 1'b0;
            check_eq("start_on_done_ignored", bif.busy, 0);
        end
        repeat (2) @(negedge clk);
        check_txn(r, a, n, s_cyc);
        wexp.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bif.start = 1'b0; bif.rw = 1'b0; bif.addr = '0; bif.len = '0;
`ifdef SPI_BURST_ABORT_EN
        bif.abort = 1'b0;
`endif
        clear_logs();
        repeat (2) @(negedge clk);
        check_eq("rst_cs_n", bif.cs_n, 1);
        check_eq("rst_busy", bif.busy, 0);
        check_eq("rst_spi_start", bif.spi_start, 0);
        check_eq("rst_spi_tx", bif.spi_tx, 0);
        check_eq("rst_wr_ready", bif.wr_ready, 0);
        check_eq("rst_rd_valid", bif.rd_valid, 0);
        check_eq("rst_rd_data", bif.rd_data, 0);
        check_eq("rst_done", bif.done, 0);
        rst_n = 1'b1;

        wexp = '{8'hA5, 8'h3C};
        run_txn(1'b0, 7'h15, 2, 0);
        rx_preset = '{8'hEE, 8'h11, 8'h22, 8'h33};
        run_txn(1'b1, 7'h02, 3, 0);
        run_txn(1'b1, 7'h7F, 0, 1);

        hold_rdy = 0;
        hold_cycles = 20;
        run_txn(1'b0, 7'h5A, 1, 0);
        check_eq("hold_ready_high", hold_rdy, 20);
        check_eq("hold_no_start", starts_at_rel, 1);
        check_eq("hold_release", start_cyc_log.size() > 1 ? start_cyc_log[1] - rel_cyc : -1, 1);

        run_txn(1'b0, 7'h40, 15, 0);
        run_txn(1'b1, 7'h41, 15, 0);

        clear_logs();
        @(negedge clk);
        bif.start = 1'b1; bif.rw = 1'b1; bif.addr = 7'h2A; bif.len = LEN_W'(4);
        @(negedge clk);
        bif.start = 1'b0;
        wait_bytes(3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_cs_n", bif.cs_n, 1);
        check_eq("midrst_busy", bif.busy, 0);
        check_eq("midrst_spi_start", bif.spi_start, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_eq("midrst_no_done", done_cnt, 0);
        run_txn(1'b1, 7'h11, 4, 0);

`ifdef SPI_BURST_ABORT_EN
        clear_logs();
        @(negedge clk);
        bif.start = 1'b1; bif.rw = 1'b1; bif.addr = 7'h33; bif.len = LEN_W'(5);
        @(negedge clk);
        bif.start = 1'b0;
        wait_bytes(3);
        @(negedge clk);
        bif.abort = 1'b1;
        @(negedge clk);
        bif.abort = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);
        check_eq("abort_n_bytes", tx_log.size(), 3);
        check_eq("abort_n_rd", rd_log.size(), 2);
        if (rd_log.size() == 2 && rx_log.size() >= 3) check_eq("abort_rd_last", rd_log[1], rx_log[2]);
        check_eq("abort_done", done_cnt, 1);
        check_eq("abort_flag", aborted_cnt, 1);
        check_eq("abort_cs_hold", done_cyc - last_nd_cyc, CS_DLY + 1);
`endif

        stall_en = 1;
        for (int k = 0; k < 12; k++) begin
            lat_max = $urandom_range(1, 4);
            run_txn(1'($urandom_range(0, 1)), 7'($urandom), $urandom_range(0, 15), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
